// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART transmit control stage.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic TX_IDLE_LVL  = 1'b1;
    localparam logic TX_START_LVL = 1'b0;
    localparam logic TX_STOP_LVL  = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_fsm_parity_calc.sv
// Combinational parity of one payload word; odd parity inverts the XOR reduce.
module parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  parity_o
);

    assign parity_o = (^data_i) ^ (par_typ_i == PAR_ODD);

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit control: sequences start, data, optional parity and stop bits,
// steering an external serializer and registering the final TX line.
module uart_tx_fsm
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  SER_DATA,
    input  logic                  SER_DONE,
    output logic                  SER_EN,
    output logic                  busy,
    output logic                  TX_OUT
);

    tx_state_e state_q;
    logic      parity_q;
    logic      par_en_q;
    logic      tx_out_q;
    logic      parity_d;
    logic      tx_line_d;

    // Parity of the byte presented at acceptance; latched below.
    parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .data_i    (P_DATA),
        .par_typ_i (PAR_TYP),
        .parity_o  (parity_d)
    );

    // Pre-register line mux: the level each state puts on the wire.
    always_comb begin
        // NOTE: default first so every path assigns tx_line_d and no latch is inferred.
        tx_line_d = TX_IDLE_LVL;
        unique case (state_q)
            IDLE:    tx_line_d = TX_IDLE_LVL;
            START:   tx_line_d = TX_START_LVL;
            DATA:    tx_line_d = SER_DATA;
            PARITY:  tx_line_d = parity_q;
            STOP:    tx_line_d = TX_STOP_LVL;
            default: tx_line_d = TX_IDLE_LVL;
        endcase
    end

    // Frame sequencer with acceptance latches and the registered TX line.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            parity_q <= 1'b0;
            par_en_q <= 1'b0;
            tx_out_q <= TX_IDLE_LVL;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            tx_out_q <= tx_line_d;
            case (state_q)
                IDLE: begin
                    if (DATA_VALID) begin
                        state_q  <= START;
                        parity_q <= parity_d;
                        par_en_q <= PAR_EN;
                    end
                end
                START: state_q <= DATA;
                DATA: begin
                    if (SER_DONE) begin
                        state_q <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY:  state_q <= STOP;
                STOP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // busy rises the cycle the FSM leaves IDLE so the serializer cannot reload mid-frame.
    assign busy   = (state_q != IDLE);
    // Shift in START so bit 0 is ready for the first DATA cycle; drop on SER_DONE so the
    // serializer counter clears.
    assign SER_EN = (state_q == START) | ((state_q == DATA) & ~SER_DONE);
    assign TX_OUT = tx_out_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm with a behavioural 8-bit serializer model.
module tb_uart_tx_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       SER_DATA;
    logic       SER_DONE;
    logic       SER_EN;
    logic       busy;
    logic       TX_OUT;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]  p_data;
        logic        par_en;
        logic        par_typ;
        logic        toggle_mid;
        logic        extra_pulse;
        int          len;
        logic [10:0] exp_seq;  // bit i = i-th frame bit on the line
    } vec_t;

    vec_t vecs[6];

    uart_tx_fsm #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .SER_DATA   (SER_DATA),
        .SER_DONE   (SER_DONE),
        .SER_EN     (SER_EN),
        .busy       (busy),
        .TX_OUT     (TX_OUT)
    );

    always #5 CLK = ~CLK;

    // Serializer model: loads while idle, shifts LSB first into a registered bit.
    logic [7:0] ser_sr;
    logic [3:0] ser_cnt;
    logic       ser_data_q;
    logic       ser_done_force = 1'b0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ser_sr     <= 8'h00;
            ser_cnt    <= 4'd0;
            ser_data_q <= 1'b0;
        end else if (!busy) begin
            ser_sr  <= P_DATA;
            ser_cnt <= 4'd0;
        end else if (SER_EN) begin
            ser_data_q <= ser_sr[0];
            ser_sr     <= ser_sr >> 1;
            ser_cnt    <= ser_cnt + 4'd1;
        end else if (ser_cnt == 4'd8) begin
            ser_cnt <= 4'd0;
        end
    end

    assign SER_DATA = ser_data_q;
    assign SER_DONE = (ser_cnt == 4'd8) | ser_done_force;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Caller is at a negedge. Issues one DATA_VALID pulse, then samples cycles 1..last_j
    // after the accepting edge; returns at the negedge of cycle last_j.
    task automatic run_frame(input vec_t v, input int last_j);
        logic [15:0] busy_m, en_m, exp_b, exp_e;
        busy_m = '0; en_m = '0; exp_b = '0; exp_e = '0;
        P_DATA     = v.p_data;
        PAR_EN     = v.par_en;
        PAR_TYP    = v.par_typ;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        for (int j = 1; j <= last_j; j++) begin
            if (j > 1) @(negedge CLK);
            busy_m[j] = busy;
            en_m[j]   = SER_EN;
            exp_b[j]  = (j <= v.len);
            exp_e[j]  = (j <= 8);
            if (j >= 2 && j <= v.len + 1)
                check($sformatf("tx_bit%0d_%0h", j - 2, v.p_data), TX_OUT, v.exp_seq[j-2]);
            if (j == v.len + 2)
                check("tx_idle_after_stop", TX_OUT, 1);
            if (j == 4 && v.toggle_mid) begin
                PAR_TYP = ~PAR_TYP;
                PAR_EN  = ~PAR_EN;
            end
            if (j == 4 && v.extra_pulse) begin
                P_DATA     = 8'hFF;
                DATA_VALID = 1'b1;
            end
            if (j == 5) DATA_VALID = 1'b0;
        end
        check($sformatf("busy_mask_%0h", v.p_data), busy_m, exp_b);
        check($sformatf("ser_en_mask_%0h", v.p_data), en_m, exp_e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen_busy, seen_low;
        vec_t v3c, vff;

        //            data   pen   ptyp  tog   xtra  len  expected line bits
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 10, 11'b111_0100_1010};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 11, 11'b101_0100_1010};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 11, 11'b111_0100_1010};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 11, 11'b110_0000_0010};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 10, 11'b110_0111_1000};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 11, 11'b110_0000_0000};
        v3c     = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 10, 11'b110_0111_1000};
        vff     = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 10, 11'b111_1111_1110};

        RST = 1'b0; P_DATA = 8'h00; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_tx_out", TX_OUT, 1);
        check("reset_busy", busy, 0);
        check("reset_ser_en", SER_EN, 0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // Reset asserted while the start bit is on the line.
        P_DATA = 8'hA5; PAR_EN = 1'b0; DATA_VALID = 1'b1;
        @(negedge CLK); DATA_VALID = 1'b0;
        @(negedge CLK);
        check("pre_reset_start_bit", TX_OUT, 0);
        check("pre_reset_busy", busy, 1);
        RST = 1'b0;
        #1;
        check("async_reset_tx_out", TX_OUT, 1);
        check("async_reset_busy", busy, 0);
        check("async_reset_ser_en", SER_EN, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        seen_busy = 1'b0; seen_low = 1'b0;
        repeat (12) begin
            @(negedge CLK);
            seen_busy |= busy;
            seen_low  |= ~TX_OUT;
        end
        check("no_busy_after_reset", seen_busy, 0);
        check("no_bits_after_reset", seen_low, 0);

        // SER_DONE while idle must not start anything.
        ser_done_force = 1'b1;
        repeat (3) @(negedge CLK);
        check("idle_ser_done_busy", busy, 0);
        check("idle_ser_done_tx", TX_OUT, 1);
        check("idle_ser_done_ser_en", SER_EN, 0);
        ser_done_force = 1'b0;
        @(negedge CLK);

        foreach (vecs[i]) begin
            run_frame(vecs[i], 14);
            @(negedge CLK);
        end

        // Pulse in the first IDLE cycle after STOP starts the next frame immediately.
        run_frame(v3c, 11);
        check("first_idle_after_stop", busy, 0);
        run_frame(vff, 14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
